// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared constants for the multiplier host. Contains the state
//            encoding, the default operand width and the product width helper.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // The state register is 3 bits wide.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // The product of two w-bit operands is 2*w bits wide.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_host_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : wait_timer
// Purpose  : Watchdog counter that can be cleared and saturates at TIMEOUT.
//            o_tc is high while the count equals TIMEOUT-1.
// Ports    : i_clk  - clock
//            i_rst  - synchronous active-high reset
//            i_clr  - synchronous clear; takes priority over i_en
//            i_en   - count enable
//            o_tc   - terminal count (count == TIMEOUT-1)
// Revision : 1.0 - initial release
// ============================================================================
module wait_timer #(
  parameter int TIMEOUT = 40
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] c_TC  = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // The counter stops at TIMEOUT and does not wrap, so a long enable
  // cannot produce a second terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == c_TC);

endmodule
`default_nettype wire

// File: rtl/mult_host.sv
`default_nettype none
// ============================================================================
// Module   : mult_host
// Purpose  : Initiator side of the shift-add multiplier handshake. Takes an
//            operand pair from upstream, pulses valid_data to the multiplier,
//            waits for Done_Flag (under a watchdog), acknowledges it, and
//            offers the product downstream.
// Ports    : i_clk/i_rst              - clock, synchronous active-high reset
//            i_req_valid/o_req_ready  - upstream operand handshake
//            i_req_a/i_req_b          - operands
//            o_mul_valid_data         - one-cycle issue pulse to multiplier
//            o_mul_a/o_mul_b          - registered operands to multiplier
//            i_mul_done/i_mul_product - multiplier done flag and product
//            o_mul_ack                - one-cycle acknowledge to multiplier
//            o_rsp_valid/i_rsp_ready  - downstream result handshake
//            o_rsp_product            - captured product (0 on timeout)
//            o_rsp_timeout            - result is an aborted transaction
//            o_busy                   - not idle
// Revision : 1.0 - initial release
// ============================================================================
module mult_host
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 40
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [WIDTH-1:0]             i_req_a,
  input  logic [WIDTH-1:0]             i_req_b,
  output logic                         o_mul_valid_data,
  output logic [WIDTH-1:0]             o_mul_a,
  output logic [WIDTH-1:0]             o_mul_b,
  input  logic                         i_mul_done,
  input  logic [prod_width(WIDTH)-1:0] i_mul_product,
  output logic                         o_mul_ack,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [prod_width(WIDTH)-1:0] o_rsp_product,
  output logic                         o_rsp_timeout,
  output logic                         o_busy
);

  localparam int PW = prod_width(WIDTH);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_product;
  logic             r_timeout;
  logic             w_tc;

  // Watchdog: cleared during ISSUE so every WAIT starts counting from zero.
  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state == ST_ISSUE),
    .i_en  (r_state == ST_WAIT),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_req_valid) w_state_nxt = ST_ISSUE;
      // A done flag seen while issuing is stale and is deliberately ignored.
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_mul_done) begin
          w_state_nxt = ST_ACK;
        end else if (w_tc) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_ACK:   w_state_nxt = ST_RESP;
      ST_RESP:  if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && i_req_valid) begin
        r_a <= i_req_a;
        r_b <= i_req_b;
      end
      // Done has priority over the watchdog when both occur together.
      if (r_state == ST_WAIT) begin
        if (i_mul_done) begin
          r_product <= i_mul_product;
          r_timeout <= 1'b0;
        end else if (w_tc) begin
          r_product <= '0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_req_ready      = (r_state == ST_IDLE);
  assign o_mul_valid_data = (r_state == ST_ISSUE);
  assign o_mul_ack        = (r_state == ST_ACK);
  assign o_rsp_valid      = (r_state == ST_RESP);
  assign o_busy           = (r_state != ST_IDLE);
  assign o_mul_a          = r_a;
  assign o_mul_b          = r_b;
  assign o_rsp_product    = r_product;
  assign o_rsp_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mult_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_host
// Purpose  : Self-checking bench for mult_host. A behavioural multiplier
//            model answers each issued pair after a chosen delay; expected
//            products come from plain 64-bit arithmetic and expected
//            latencies from the handshake timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_host;

  localparam int W  = 32;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          mul_valid_data;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_done = 1'b0;
  logic [2*W-1:0] mul_product = '0;
  logic          mul_ack;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [2*W-1:0] rsp_product;
  logic          rsp_timeout;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_vd     = 0;
  int n_ack    = 0;
  int n_rsp    = 0;

  always #5 clk = ~clk;

  mult_host #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_a          (req_a),
    .i_req_b          (req_b),
    .o_mul_valid_data (mul_valid_data),
    .o_mul_a          (mul_a),
    .o_mul_b          (mul_b),
    .i_mul_done       (mul_done),
    .i_mul_product    (mul_product),
    .o_mul_ack        (mul_ack),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_product    (rsp_product),
    .o_rsp_timeout    (rsp_timeout),
    .o_busy           (busy)
  );

  // Pulse monitors: count cycles each handshake strobe is high.
  always @(posedge clk) begin
    if (!rst) begin
      if (mul_valid_data) n_vd  <= n_vd + 1;
      if (mul_ack)        n_ack <= n_ack + 1;
      if (rsp_valid)      n_rsp <= n_rsp + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction. d = cycles after ISSUE at which the model raises
  // done (0 or > TO means never). hold = RESP cycles with rsp_ready low.
  // stale = raise a bogus done during ISSUE.
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b,
                     input int d, input int hold, input bit stale);
    int vd0, ak0, k;
    bit to;
    logic [63:0] exp;
    vd0 = n_vd;
    ak0 = n_ack;
    to  = (d == 0) || (d > TO);
    exp = to ? 64'd0 : ({32'd0, a} * {32'd0, b});
    rsp_ready   = (hold == 0);
    mul_product = {$urandom, $urandom};
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b;
    @(negedge clk);                          // ISSUE
    req_valid = 1'b0;
    chk("issue_pulse", mul_valid_data, 1'b1);
    chk("mul_a", mul_a, a);
    chk("mul_b", mul_b, b);
    if (stale) begin
      mul_done = 1'b1;
      mul_product = ~exp;
    end
    @(negedge clk);                          // first WAIT cycle
    mul_done = 1'b0;
    if (to) begin
      k = 0;
      while (!rsp_valid && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("timeout_latency", k, TO);
    end else begin
      repeat (d - 1) @(negedge clk);
      mul_done = 1'b1;
      mul_product = exp;
      @(negedge clk);                        // ACK
      chk("ack_pulse", mul_ack, 1'b1);
      mul_done = 1'b0;
      mul_product = {$urandom, $urandom};
      @(negedge clk);                        // RESP
    end
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_product", rsp_product, exp);
    chk("rsp_timeout", rsp_timeout, to);
    chk("req_ready_resp", req_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_a = ~a; req_b = ~b;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_product", rsp_product, exp);
      chk("hold_timeout", rsp_timeout, to);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);                          // back in IDLE
    chk("idle_req_ready", req_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("vd_count", n_vd - vd0, 1);
    chk("ack_count", n_ack - ak0, to ? 0 : 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_vd"}, mul_valid_data, 1'b0);
    chk({tag, "_ack"}, mul_ack, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_timeout"}, rsp_timeout, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_product"}, rsp_product, 0);
  endtask

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    txn(32'd3, 32'd5, 33, 0, 1'b0);
    txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0, 1'b0);
    txn(32'd7, 32'd9, 0, 0, 1'b0);              // done never arrives
    txn(32'd12, 32'd11, 6, 10, 1'b0);           // backpressure
    txn(32'd100, 32'd200, 5, 0, 1'b1);          // stale done during ISSUE
    txn(32'd21, 32'd2, TO, 0, 1'b0);            // done on terminal count
    txn(32'd1, 32'd1, 1, 0, 1'b0);              // fastest done

    for (int i = 0; i < 6; i++) begin
      txn($urandom, $urandom, $urandom_range(1, TO), $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    // Reset during the 5th WAIT cycle abandons the transaction.
    r0 = n_rsp;
    req_valid = 1'b1; req_a = 32'd6; req_b = 32'd7;
    @(negedge clk);                             // ISSUE
    req_valid = 1'b0;
    repeat (5) @(negedge clk);                  // 5th WAIT cycle
    chk("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midreset");
    repeat (60) @(negedge clk);
    chk("no_rsp_after_reset", n_rsp - r0, 0);

    txn(32'd8, 32'd8, 3, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_host.md
Name: mult_host

Overview:
- Initiator side of the shift-add multiplier handshake (valid_data / Done_Flag / ack).
- Accepts operand pairs from an upstream valid/ready source and issues each pair to the multiplier with a one-cycle valid_data pulse.
- Waits for the done flag, captures the product and acknowledges it, then presents the result downstream on a valid/ready port.
- A watchdog aborts a transaction if the multiplier never reports done.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH bits.
- TIMEOUT, 40: maximum cycles spent in WAIT before aborting.

Ports:
- Clock  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  upstream operand pair valid.
- req_ready  out  1  block can accept a pair.
- req_a  in  WIDTH  operand a.
- req_b  in  WIDTH  operand b.
- mul_valid_data  out  1  to multiplier valid_data.
- mul_a  out  WIDTH  operand a to datapath; held stable from ISSUE through ACK.
- mul_b  out  WIDTH  operand b to datapath; held stable from ISSUE through ACK.
- mul_done  in  1  multiplier Done_Flag.
- mul_product  in  2*WIDTH  multiplier product.
- mul_ack  out  1  to multiplier ack.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_product  out  2*WIDTH  captured product; 0 on timeout.
- rsp_timeout  out  1  result is an aborted transaction.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (sampled at the rising edge of Clock):
  - State goes to IDLE; operand, product and timeout registers clear to 0; watchdog counter clears to 0.
  - Resulting outputs: req_ready=1; mul_valid_data, mul_ack, rsp_valid, rsp_timeout and busy=0; mul_a, mul_b and rsp_product=0.
  - Reset mid-operation abandons the transaction with no response. The multiplier shares Reset and returns to its own IDLE on the same edge.
- Outputs are Moore-decoded from the state register; data outputs come from registers.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture req_a/req_b into mul_a/mul_b and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mul_valid_data=1 for exactly one cycle; clear the watchdog; go to WAIT unconditionally.
  - mul_done is ignored in this state (a stale done flag is not a result).
- WAIT:
  - Watchdog increments every cycle.
  - If mul_done=1: capture mul_product, set the timeout register to 0, go to ACK.
  - Else if watchdog = TIMEOUT-1: set rsp_product=0 and timeout register=1, go to RESP. mul_ack is not asserted.
  - If done and the watchdog limit occur in the same cycle, done wins.
- ACK:
  - mul_ack=1 for exactly one cycle, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_product and rsp_timeout are held stable.
  - On rsp_ready=1, go to IDLE; otherwise hold indefinitely.
  - req_ready=0 throughout.
- Latency (request accepted at edge N, multiplier reports done D cycles after ISSUE):
  - mul_valid_data is high in cycle N+1.
  - rsp_valid is first high in cycle N+D+3.
  - With rsp_ready held high, at most one transaction is in flight; the next req_ready is asserted the cycle after the response handshake.
- Watchdog width: clog2(TIMEOUT+1); saturates and never wraps.
- Multiplication is performed entirely by the multiplier; this block does no arithmetic beyond the watchdog counter.

Decomposition:
- Package mult_pkg holds:
  - state encoding constants IDLE=0, ISSUE=1, WAIT=2, ACK=3, RESP=4 (3-bit state);
  - default WIDTH;
  - the product width expression 2*WIDTH.
- One sub-module, wait_timer: a clearable, saturating counter with a terminal-count output at TIMEOUT-1. It is instantiated once by mult_host.

Test Plan:
- a=3, b=5, multiplier model reports done 33 cycles after ISSUE → one mul_valid_data pulse; mul_ack pulses once; rsp_product=15; rsp_timeout=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF → rsp_product=0xFFFFFFFE00000001.
- mul_done never asserted, TIMEOUT=40 → rsp_valid rises 40 cycles after entering WAIT; rsp_timeout=1; rsp_product=0; mul_ack never asserted.
- rsp_ready held low for 10 cycles in RESP → rsp_valid, rsp_product and rsp_timeout stay stable; req_ready=0 while req_valid=1. On rsp_ready=1 → IDLE, and the next pair is accepted the following cycle.
- Reset asserted in the 5th WAIT cycle → next cycle in IDLE with all outputs at reset values; no rsp_valid ever appears for the aborted pair.
- mul_done=1 during ISSUE only, real done later → product captured only at the later done; mul_done coinciding with watchdog terminal count → rsp_timeout=0 and the product is captured.
